// File: rtl/periph_pkg.sv
// Shared definitions for memory-mapped peripherals: register offsets, CON bit
// positions and the UART receiver state encoding.
package periph_pkg;

  localparam logic [31:0] RXD_OFF = 32'h0000_0000;
  localparam logic [31:0] CON_OFF = 32'h0000_0004;

  localparam int unsigned CON_RX_VALID  = 0;
  localparam int unsigned CON_OVERRUN   = 1;
  localparam int unsigned CON_FRAME_ERR = 2;
  localparam int unsigned CON_IRQ_EN    = 3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } rx_state_e;

  // Word-granular address match; byte lanes are not decoded.
  function automatic logic word_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// Peripheral bus seen by the UART receiver: CPU drives strobes, address and
// write data; the peripheral returns combinational read data.
interface uart_rx_port_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd,
    output wr,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  rd,
    input  wr,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick every BAUD_DIV cycles; held at
// zero while clr is asserted so the first tick lands a full period after clr drops.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling FSM, one-byte holding
// register with overrun/framing status and a level interrupt.
module uart_rx_port
  import periph_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 27,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_port_if.slave  bus,
  input  logic           uart_rx,
  output logic           irq
);

  localparam logic [31:0] RxdAddr = BASE_ADDR + RXD_OFF;
  localparam logic [31:0] ConAddr = BASE_ADDR + CON_OFF;

  logic      rx_meta_q, rx_sync_q;
  rx_state_e state_q, state_d;
  logic [3:0] sub_q, sub_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       deliver_q, deliver_d;
  logic       ferr_set;
  logic       tick, tick_clr;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_q;

  logic rxd_hit, con_hit, rd_rxd, con_wr;
  logic unused_bus_bits;

  assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:4], bus.wdata[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick_clr = (state_q == StIdle);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    deliver_d = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sub_d = '0;
        bit_d = '0;
        if (!rx_sync_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          // Mid start bit: a high line here was only a glitch.
          if (sub_q == 4'd7) begin
            sub_d   = '0;
            bit_d   = '0;
            state_d = rx_sync_q ? StIdle : StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shreg_d = {rx_sync_q, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            if (rx_sync_q) begin
              deliver_d = 1'b1;
              state_d   = StIdle;
            end else begin
              ferr_set = 1'b1;
              state_d  = StBreak;
            end
          end
        end
      end
      StBreak: begin
        if (rx_sync_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sub_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      deliver_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      deliver_q <= deliver_d;
    end
  end

  assign rxd_hit = word_hit(bus.addr, RxdAddr);
  assign con_hit = word_hit(bus.addr, ConAddr);
  assign rd_rxd  = bus.rd & rxd_hit;
  assign con_wr  = bus.wr & con_hit;

  // Read clear goes first so a same-cycle delivery reloads instead of overrunning;
  // hardware sets come after W1C so they win.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    irq_en_d    = irq_en_q;
    if (rd_rxd) begin
      rx_valid_d = 1'b0;
    end
    if (con_wr) begin
      irq_en_d = bus.wdata[CON_IRQ_EN];
      if (bus.wdata[CON_OVERRUN]) begin
        overrun_d = 1'b0;
      end
      if (bus.wdata[CON_FRAME_ERR]) begin
        frame_err_d = 1'b0;
      end
    end
    if (ferr_set) begin
      frame_err_d = 1'b1;
    end
    if (deliver_q) begin
      if (rx_valid_d) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_en_q & rx_valid_q;
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (rxd_hit) begin
        bus.rdata = {24'b0, rx_data_q};
      end else if (con_hit) begin
        bus.rdata[CON_RX_VALID]  = rx_valid_q;
        bus.rdata[CON_OVERRUN]   = overrun_q;
        bus.rdata[CON_FRAME_ERR] = frame_err_q;
        bus.rdata[CON_IRQ_EN]    = irq_en_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: drives 8N1 frames at BAUD_DIV=4 (64 clk/bit)
// and checks registers against a small reference model with a byte scoreboard.
module tb_uart_rx_port;

  localparam logic [31:0] RxdA = 32'h4000_0018;
  localparam logic [31:0] ConA = 32'h4000_001C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic irq;

  uart_rx_port_if bus();

  uart_rx_port #(
    .BAUD_DIV  (4),
    .BASE_ADDR (32'h4000_0018)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_rx (uart_rx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the register file.
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_ien = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [31:0] exp_con;
    logic [31:0] exp_con_after;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [31:0] model_con();
    return {28'b0, m_ien, m_ferr, m_ovr, m_valid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.rd   = 1'b1;
    bus.addr = a;
    #1 d = bus.rdata;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic con_check(input string name);
    logic [31:0] v;
    bus_read(ConA, v);
    check(name, v, model_con());
  endtask

  task automatic rxd_check(input string name);
    logic [31:0] v;
    bus_read(RxdA, v);
    if (exp_q.size() > 0) m_data = exp_q.pop_front();
    m_valid = 1'b0;
    check(name, v, {24'b0, m_data});
  endtask

  task automatic con_write(input logic [31:0] d);
    bus_write(ConA, d);
    m_ien = d[3];
    if (d[1]) m_ovr = 1'b0;
    if (d[2]) m_ferr = 1'b0;
  endtask

  // Stop bit 0 leaves the line low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit track);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (64) @(negedge clk);
    end
    uart_rx = stop;
    repeat (64) @(negedge clk);
    if (track) begin
      if (!stop) m_ferr = 1'b1;
      else if (m_valid) m_ovr = 1'b1;
      else begin
        exp_q.push_back(d);
        m_valid = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v, coll_rd;
    logic        found, irq_at_rise, irq_next;

    vecs[0] = '{8'hA5, 32'h1, 32'h0};
    vecs[1] = '{8'h00, 32'h1, 32'h0};
    vecs[2] = '{8'hFF, 32'h1, 32'h0};
    vecs[3] = '{8'h5A, 32'h1, 32'h0};

    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_irq", {31'b0, irq}, 32'h0);
    con_check("reset_con");
    rxd_check("reset_rxd");
    bus_read(32'h4000_0020, v);
    check("unmapped_read", v, 32'h0);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, 1'b1, 1'b1);
      bus_read(ConA, v);
      check($sformatf("vec%0d_con", i), v, vecs[i].exp_con);
      rxd_check($sformatf("vec%0d_rxd", i));
      bus_read(ConA, v);
      check($sformatf("vec%0d_con_after", i), v, vecs[i].exp_con_after);
    end

    // RXD writes are ignored.
    bus_write(RxdA, 32'hFFFF_FFFF);
    con_check("rxd_write_ignored");

    // Interrupt timing: poll CON continuously (no side effects) for rx_valid rise.
    con_write(32'h8);
    con_check("irq_en_set");
    found = 1'b0; irq_at_rise = 1'b1; irq_next = 1'b0;
    fork
      send_frame(8'h3C, 1'b1, 1'b1);
      begin
        @(negedge clk);
        bus.rd = 1'b1;
        bus.addr = ConA;
        for (int i = 0; i < 800 && !found; i++) begin
          @(negedge clk);
          if (bus.rdata[0]) begin
            found = 1'b1;
            irq_at_rise = irq;
            @(negedge clk);
            irq_next = irq;
          end
        end
        bus.rd = 1'b0;
      end
    join
    check("irq_valid_seen", {31'b0, found}, 32'h1);
    check("irq_lag_0", {31'b0, irq_at_rise}, 32'h0);
    check("irq_lag_1", {31'b0, irq_next}, 32'h1);
    con_check("irq_con");
    rxd_check("irq_rxd");
    @(negedge clk);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    con_write(32'h0);

    // Overrun.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    con_check("ovr_con");
    con_write(32'h2);
    con_check("ovr_cleared");
    rxd_check("ovr_rxd");
    con_check("ovr_con_after");

    // Framing error with line held low.
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (300) @(negedge clk);
    con_check("ferr_con");
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    con_check("ferr_no_frames");
    send_frame(8'h77, 1'b1, 1'b1);
    con_check("ferr_then_valid");
    rxd_check("ferr_rxd");
    con_write(32'h4);
    con_check("ferr_cleared");

    // Glitch on idle line.
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    con_check("glitch_con");

    // Reset mid-frame, held through the rest of the frame.
    con_write(32'h8);
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      begin
        repeat (300) @(negedge clk);
        reset = 1'b1;
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_ien = 1'b0;
        m_data = 8'h00;
        exp_q.delete();
        con_check("reset_mid_con");
      end
    join
    check("reset_mid_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    con_check("reset_after_con");
    send_frame(8'h66, 1'b1, 1'b1);
    con_check("post_reset_con");
    rxd_check("post_reset_rxd");

    // Collision: RXD read in the exact delivery cycle of the next byte.
    send_frame(8'h33, 1'b1, 1'b1);
    m_data = exp_q.pop_front();
    m_valid = 1'b0;
    coll_rd = '0;
    fork
      send_frame(8'h44, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (611) @(negedge clk);
        bus.rd = 1'b1;
        bus.addr = RxdA;
        #1 coll_rd = bus.rdata;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    join
    check("coll_old_byte", coll_rd, {24'b0, m_data});
    con_check("coll_con");
    rxd_check("coll_rxd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
